// File: rtl/audio_pkg.sv
// Shared definitions for the time-multiplexed PSG/beeper mixer and its sigma-delta outputs.
package audio_pkg;

   localparam logic [1:0] PAN_OFF = 2'b00;
   localparam logic [1:0] PAN_L   = 2'b01;
   localparam logic [1:0] PAN_R   = 2'b10;
   localparam logic [1:0] PAN_LR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      BEEP,
      SAT
   } mix_state_e;

   // Ceiling log2 usable in constant expressions; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/audio_mixer_sd_if.sv
// Channel/pan/beeper inputs and parallel sample outputs of the audio mixer.
interface audio_mixer_sd_if #(
   parameter int NUM_CH = 3,
   parameter int CH_W   = 8,
   parameter int OUT_W  = 8
);

   logic [NUM_CH*CH_W-1:0] ch_in;
   logic [2*NUM_CH-1:0]    pan_cfg;
   logic                   mic;
   logic                   ear;
   logic [OUT_W-1:0]       sample_l;
   logic [OUT_W-1:0]       sample_r;
   logic                   sample_valid;
   logic                   clip_l;
   logic                   clip_r;

   modport master (
      output ch_in, pan_cfg, mic, ear,
      input  sample_l, sample_r, sample_valid, clip_l, clip_r
   );

   modport slave (
      input  ch_in, pan_cfg, mic, ear,
      output sample_l, sample_r, sample_valid, clip_l, clip_r
   );

endinterface

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry of a running sum is the 1-bit output.
module sigma_delta_dac #(
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OUT_W-1:0] sample,
   output logic             bit_out
);

   logic [OUT_W:0] sd;

   always_ff @(posedge clk) begin
      if (rst) begin
         sd <= '0;
      end else begin
         sd <= {1'b0, sd[OUT_W-1:0]} + {1'b0, sample};
      end
   end

   assign bit_out = sd[OUT_W];

endmodule

// File: rtl/audio_mixer_sd.sv
// Mixes NUM_CH panned channels plus mic/ear beepers into saturated L/R samples once per
// SAMPLE_DIV clocks, and drives each side out as a sigma-delta bitstream.
module audio_mixer_sd
   import audio_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int CH_W       = 8,
   parameter int OUT_W      = 8,
   parameter int SAMPLE_DIV = 64,
   parameter int SHIFT      = 1,
   parameter int BEEP_LEVEL = 64
) (
   input  logic            clk,
   input  logic            rst,
   audio_mixer_sd_if.slave bus,
   output logic            audio_out_left,
   output logic            audio_out_right
);

   localparam int ACC_W = CH_W + clog2(NUM_CH + 2) + 1;
   localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;
   localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);
   localparam logic [CMP_W-1:0] SAT_MAX    = CMP_W'((2 ** OUT_W) - 1);
   localparam logic [OUT_W-1:0] FULL_SCALE = '1;
   localparam logic [ACC_W-1:0] BEEP_ACC   = ACC_W'(BEEP_LEVEL);

   if (SAMPLE_DIV < NUM_CH + 3) begin : g_bad_div
      $error("audio_mixer_sd: SAMPLE_DIV must be at least NUM_CH+3");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("audio_mixer_sd: NUM_CH must be in 1..8");
   end

   mix_state_e       state;
   mix_state_e       state_nxt;
   logic [DIV_W-1:0] div;
   logic [IDX_W-1:0] idx;
   logic [CH_W-1:0]  snap_ch  [NUM_CH];
   logic [1:0]       snap_pan [NUM_CH];
   logic             mic_s;
   logic             ear_s;
   logic [ACC_W-1:0] acc_l;
   logic [ACC_W-1:0] acc_r;
   logic [OUT_W-1:0] sample_l;
   logic [OUT_W-1:0] sample_r;
   logic             sample_valid;
   logic             clip_l;
   logic             clip_r;
   logic             frame_start;
   logic             last_ch;
   logic [ACC_W-1:0] beep_add;
   logic [CMP_W-1:0] shifted_l;
   logic [CMP_W-1:0] shifted_r;
   logic             over_l;
   logic             over_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      last_ch     = (idx == IDX_LAST);
      unique case (state)
         IDLE: begin
            if (div == '0) begin
               frame_start = 1'b1;
               state_nxt   = ACCUM;
            end
         end
         ACCUM: begin
            if (last_ch) begin
               state_nxt = BEEP;
            end
         end
         BEEP:    state_nxt = SAT;
         SAT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Saturation is evaluated combinationally and only committed in SAT.
   always_comb begin
      beep_add = '0;
      if (mic_s) begin
         beep_add = beep_add + BEEP_ACC;
      end
      if (ear_s) begin
         beep_add = beep_add + BEEP_ACC;
      end
      shifted_l = CMP_W'(acc_l >> SHIFT);
      shifted_r = CMP_W'(acc_r >> SHIFT);
      over_l    = (shifted_l > SAT_MAX);
      over_r    = (shifted_r > SAT_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div          <= '0;
         idx          <= '0;
         mic_s        <= 1'b0;
         ear_s        <= 1'b0;
         acc_l        <= '0;
         acc_r        <= '0;
         sample_l     <= '0;
         sample_r     <= '0;
         sample_valid <= 1'b0;
         clip_l       <= 1'b0;
         clip_r       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            snap_ch[i]  <= '0;
            snap_pan[i] <= PAN_OFF;
         end
      end else begin
         div          <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         sample_valid <= 1'b0;
         clip_l       <= 1'b0;
         clip_r       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     snap_ch[i]  <= bus.ch_in[i*CH_W +: CH_W];
                     snap_pan[i] <= bus.pan_cfg[2*i +: 2];
                  end
                  mic_s <= bus.mic;
                  ear_s <= bus.ear;
                  acc_l <= '0;
                  acc_r <= '0;
                  idx   <= '0;
               end
            end
            ACCUM: begin
               if ((snap_pan[idx] & PAN_L) != PAN_OFF) begin
                  acc_l <= acc_l + ACC_W'(snap_ch[idx]);
               end
               if ((snap_pan[idx] & PAN_R) != PAN_OFF) begin
                  acc_r <= acc_r + ACC_W'(snap_ch[idx]);
               end
               idx <= idx + IDX_W'(1);
            end
            BEEP: begin
               acc_l <= acc_l + beep_add;
               acc_r <= acc_r + beep_add;
            end
            SAT: begin
               sample_l     <= over_l ? FULL_SCALE : shifted_l[OUT_W-1:0];
               sample_r     <= over_r ? FULL_SCALE : shifted_r[OUT_W-1:0];
               clip_l       <= over_l;
               clip_r       <= over_r;
               sample_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.sample_l     = sample_l;
   assign bus.sample_r     = sample_r;
   assign bus.sample_valid = sample_valid;
   assign bus.clip_l       = clip_l;
   assign bus.clip_r       = clip_r;

   sigma_delta_dac #(.OUT_W(OUT_W)) u_sd_left (
      .clk     (clk),
      .rst     (rst),
      .sample  (sample_l),
      .bit_out (audio_out_left)
   );

   sigma_delta_dac #(.OUT_W(OUT_W)) u_sd_right (
      .clk     (clk),
      .rst     (rst),
      .sample  (sample_r),
      .bit_out (audio_out_right)
   );

endmodule

// File: doc/audio_mixer_sd.md
Name: audio_mixer_sd

Overview:
- Parametrised successor to the fixed 3-channel PSG mixer in the CPC core.
- Time-multiplexes NUM_CH unsigned PSG/auxiliary channels and two 1-bit beeper sources (mic, ear) into left and right sums.
- Each channel has a runtime pan, giving ABC/ACB/mono modes.
- Results are saturated, published as parallel samples for digital audio sinks, and driven out as first-order sigma-delta 1-bit streams for the board's RC filters.

Parameters:
- NUM_CH, 3: number of input channels (range 1..8).
- CH_W, 8: width of each channel sample, unsigned.
- OUT_W, 8: width of the output sample and of the sigma-delta input.
- SAMPLE_DIV, 64: clocks per mix frame; must be >= NUM_CH+3, checked at elaboration.
- SHIFT, 1: right shift applied to each raw sum before saturation.
- BEEP_LEVEL, 64: amplitude added to both sides per asserted beeper (fits CH_W).

Ports:
- clk  in  1  system clock, 16 MHz domain.
- rst  in  1  synchronous, active-high reset.
- ch_in  in  NUM_CH*CH_W  packed channel samples; channel i occupies bits [i*CH_W +: CH_W].
- pan_cfg  in  2*NUM_CH  per-channel pan; channel i occupies bits [2i +: 2]. 00 = off, 01 = left, 10 = right, 11 = both.
- mic  in  1  tape-out beeper.
- ear  in  1  tape-in beeper.
- sample_l  out  OUT_W  latest saturated left sample.
- sample_r  out  OUT_W  latest saturated right sample.
- sample_valid  out  1  one-clock pulse when sample_l/sample_r update.
- clip_l  out  1  one-clock pulse, coincident with sample_valid, when left saturated.
- clip_r  out  1  as clip_l, for right.
- audio_out_left  out  1  sigma-delta bitstream, left.
- audio_out_right  out  1  sigma-delta bitstream, right.

Behaviour:
- Reset: all outputs 0; div counter 0; FSM in IDLE; accumulators, snapshots and sigma-delta integrators 0.
- Accumulator width: ACC_W = CH_W + clog2(NUM_CH+2) + 1, so no overflow before saturation.
- Frame timer: div counts 0..SAMPLE_DIV-1 and wraps. div==0 while in IDLE starts a frame.
- FSM IDLE, at frame start:
  - snapshot ch_in, pan_cfg, mic, ear; inputs are stable for the whole frame;
  - clear acc_l and acc_r; idx <= 0;
  - go to ACCUM.
- FSM ACCUM, one channel per clock:
  - acc_l += snap_ch[idx] if pan bit0 is set;
  - acc_r += snap_ch[idx] if pan bit1 is set;
  - idx++; after idx == NUM_CH-1, go to BEEP.
- FSM BEEP, one clock: each side += BEEP_LEVEL*(mic_s + ear_s); go to SAT.
- FSM SAT, one clock:
  - s = acc >> SHIFT per side;
  - if s > 2^OUT_W-1, sample <= 2^OUT_W-1 and clip pulses, else sample <= s[OUT_W-1:0];
  - sample_valid <= 1 for exactly this one registered cycle;
  - go to IDLE.
- Latency: sample_valid is asserted NUM_CH+2 clocks after the frame-start clock. Exactly one sample_valid per SAMPLE_DIV clocks.
- Sigma-delta: runs every clock, independent of the FSM, on the current sample registers.
  - Integrator sd is OUT_W+1 bits: sd <= {1'b0, sd[OUT_W-1:0]} + sample.
  - audio_out = sd[OUT_W] (registered carry).
  - Long-run duty = sample / 2^OUT_W. Sample 0 gives constant 0; sample 2^OUT_W-1 gives 0 once per 2^OUT_W clocks.
- Input changes mid-frame do not affect the current frame; they are taken at the next snapshot.
- rst mid-frame: aborts immediately to the reset state. No sample_valid for the aborted frame. The first post-reset frame starts when div==0, i.e. on the first clock after rst deasserts.
- pan 00 on every channel with no beepers: samples 0, outputs constant 0.

Decomposition:
- Shared package audio_pkg:
  - PAN_OFF/PAN_L/PAN_R/PAN_LR constants;
  - FSM state enum (IDLE, ACCUM, BEEP, SAT);
  - clog2 function.
- Sub-module sigma_delta_dac (parameter OUT_W; ports clk, rst, sample, bit_out), instantiated twice, once per side.

Test Plan:
- Defaults, ch={A=100,B=50,C=20}, pan A=01, B=11, C=10, no beepers -> acc_l=150, acc_r=70; sample_l=75, sample_r=35; no clip; sample_valid exactly 5 clocks after frame start.
- All channels 255, pan 11, mic=ear=1 -> raw 893 per side, >>1 = 446 -> sample_l=sample_r=255, clip_l=clip_r=1 on the same clock as sample_valid.
- Constant sample 64, run 1024 clocks after sample_valid -> exactly 256 ones on each sigma-delta output. Sample 0 -> zero ones.
- Change ch_in from 10 to 200 two clocks into ACCUM -> current frame still uses 10 (sample_l=5 with pan 01 on A only); next frame gives 100.
- Assert rst during BEEP -> next clock all outputs 0 and no sample_valid. After release, first sample_valid arrives 5 clocks later and the period is 64 clocks thereafter.
- NUM_CH=6, CH_W=10, OUT_W=12, SHIFT=0, all channels 1000, pan 01 -> sample_l=4095 with clip_l=1, sample_r=0.
